// File: rtl/oam_dma.sv
// GameBoy OAM DMA sequencer: copies DMA_LEN bytes from (src<<8) into OAM, one byte
// per M-cycle, arbitrating the low system bus between the CPU and the DMA engine.
module oam_dma #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [15:0] REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_low_data,
    output logic [7:0]  reg_data,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE,
        STARTING,
        ACTIVE
    } state_t;

    state_t      state, state_next;
    logic [7:0]  src, src_next;
    logic [7:0]  idx, idx_next;
    logic        owned, owned_next;
    logic        reg_hit;
    logic [7:0]  eff;

    assign reg_hit = cpu_enable & cpu_write & (cpu_addr == REG_ADDR);
    // Sources in the echo region (E0..FF) read the WRAM they mirror.
    assign eff     = (src >= 8'hE0) ? src - 8'h20 : src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src   <= '0;
            idx   <= '0;
            owned <= 1'b0;
        end else begin
            state <= state_next;
            src   <= src_next;
            idx   <= idx_next;
            owned <= owned_next;
        end
    end

    always_comb begin
        state_next = state;
        src_next   = src;
        idx_next   = idx;
        owned_next = owned;
        if (m_cycle) begin
            if (reg_hit) begin
                // A restart out of ACTIVE keeps the bus so the CPU never sees a gap.
                src_next   = cpu_data_out;
                idx_next   = '0;
                state_next = STARTING;
                owned_next = (state == ACTIVE) || owned;
            end else begin
                case (state)
                    STARTING: begin
                        state_next = ACTIVE;
                        owned_next = 1'b1;
                    end
                    ACTIVE: begin
                        idx_next = idx + 8'd1;
                        if (idx == 8'(DMA_LEN - 1)) begin
                            state_next = IDLE;
                            owned_next = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cpu_low_data = 8'hFF;
        bus_addr     = '0;
        bus_enable   = 1'b0;
        bus_write    = 1'b0;
        bus_data_out = '0;
        if (!reset) begin
            if (owned) begin
                bus_addr   = {eff, idx};
                bus_enable = (state == ACTIVE);
            end else begin
                cpu_low_data = bus_data_in;
                bus_addr     = cpu_addr;
                bus_enable   = cpu_enable & (cpu_addr < 16'hFF00);
                bus_write    = cpu_write;
                bus_data_out = cpu_data_out;
            end
        end
    end

    assign oam_write  = (state == ACTIVE) & m_cycle;
    assign oam_addr   = idx;
    assign oam_data   = (state == ACTIVE) ? bus_data_in : '0;
    assign reg_data   = src;
    assign dma_active = owned;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: a random memory image feeds the bus, expected OAM
// writes are queued per transfer and popped by an independent monitor.
module tb_oam_dma;

    localparam int unsigned LEN = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_cycle;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_low_data;
    logic [7:0]  reg_data;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_data;
    logic        dma_active;

    logic [7:0]  mem [65536];
    int          checks   = 0;
    int          failures = 0;
    logic        m_en     = 1'b1;

    typedef struct {
        logic [7:0]  idx;
        logic [7:0]  data;
        logic [15:0] addr;
    } exp_t;
    exp_t exp_q[$];

    oam_dma #(.DMA_LEN(LEN), .REG_ADDR(16'hFF46)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_cycle      (m_cycle),
        .cpu_addr     (cpu_addr),
        .cpu_enable   (cpu_enable),
        .cpu_write    (cpu_write),
        .cpu_data_out (cpu_data_out),
        .cpu_low_data (cpu_low_data),
        .reg_data     (reg_data),
        .bus_addr     (bus_addr),
        .bus_enable   (bus_enable),
        .bus_write    (bus_write),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .oam_addr     (oam_addr),
        .oam_write    (oam_write),
        .oam_data     (oam_data),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;
    assign bus_data_in = mem[bus_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] eff_of(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

    // Every transfer is a straight copy of LEN bytes from the remapped page.
    task automatic push_transfer(input logic [7:0] v);
        exp_t e;
        logic [7:0] p;
        p = eff_of(v);
        for (int unsigned i = 0; i < LEN; i++) begin
            e.idx  = 8'(i);
            e.addr = {p, 8'(i)};
            e.data = mem[e.addr];
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && oam_write) begin
            chk("oam_write_strobe", m_cycle, 1);
            if (exp_q.size() == 0) begin
                chk("oam_unexpected", oam_write, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("oam_addr", oam_addr, e.idx);
                chk("oam_data", oam_data, e.data);
                chk("dma_bus_addr", bus_addr, e.addr);
                chk("dma_bus_enable", bus_enable, 1);
            end
        end
    end

    // Entry/exit invariant: 1 time unit after the first clk edge of an M-cycle.
    task automatic mcyc();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        m_cycle = m_en;
        @(posedge clk);
        #1;
        m_cycle = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] v);
        cpu_addr     = 16'hFF46;
        cpu_enable   = 1'b1;
        cpu_write    = 1'b1;
        cpu_data_out = v;
        mcyc();
        cpu_enable   = 1'b0;
        cpu_write    = 1'b0;
    endtask

    task automatic active_run(input logic [7:0] p, input int unsigned first, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cpu_addr     = ($urandom_range(0, 3) == 3) ? 16'hFF80 : 16'($urandom_range(0, 16'hFEFF));
            cpu_enable   = 1'b1;
            cpu_write    = 1'($urandom);
            cpu_data_out = 8'($urandom);
            #1;
            chk("active_dma_active", dma_active, 1);
            chk("active_bus_addr", bus_addr, {p, 8'(first + i)});
            chk("active_bus_write", bus_write, 0);
            chk("active_bus_data_out", bus_data_out, 0);
            if (cpu_addr < 16'hFF00) chk("active_cpu_low_data", cpu_low_data, 8'hFF);
            mcyc();
        end
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
    endtask

    task automatic start_and_starting(input logic [7:0] v);
        push_transfer(v);
        write_reg(v);
        cpu_addr   = 16'h1234;
        cpu_enable = 1'b1;
        #1;
        chk("starting_dma_active", dma_active, 0);
        chk("starting_bus_addr", bus_addr, 16'h1234);
        chk("starting_bus_enable", bus_enable, 1);
        chk("starting_cpu_low_data", cpu_low_data, mem[16'h1234]);
        mcyc();
        cpu_enable = 1'b0;
    endtask

    task automatic full_transfer(input logic [7:0] v);
        start_and_starting(v);
        active_run(eff_of(v), 0, LEN);
        chk("done_queue_empty", exp_q.size(), 0);
        chk("done_dma_active", dma_active, 0);
        chk("done_reg_data", reg_data, v);
    endtask

    initial begin
        logic [7:0] v;
        for (int unsigned a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        reset        = 1'b1;
        m_cycle      = 1'b0;
        cpu_addr     = 16'h1234;
        cpu_enable   = 1'b1;
        cpu_write    = 1'b1;
        cpu_data_out = 8'h77;
        #12;
        chk("reset_cpu_low_data", cpu_low_data, 8'hFF);
        chk("reset_bus_addr", bus_addr, 0);
        chk("reset_bus_enable", bus_enable, 0);
        chk("reset_bus_write", bus_write, 0);
        chk("reset_oam_write", oam_write, 0);
        chk("reset_reg_data", reg_data, 0);
        chk("reset_dma_active", dma_active, 0);
        reset      = 1'b0;
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
        @(posedge clk);
        #1;

        cpu_addr   = 16'hFF80;
        cpu_enable = 1'b1;
        #1;
        chk("idle_high_bus_enable", bus_enable, 0);
        chk("idle_high_bus_addr", bus_addr, 16'hFF80);
        cpu_enable = 1'b0;

        full_transfer(8'hC1);
        full_transfer(8'hE3);
        v = 8'($urandom);
        full_transfer(v);

        v = 8'($urandom);
        start_and_starting(v);
        active_run(eff_of(v), 0, 8'h50);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        push_transfer(8'h20);
        write_reg(8'h20);
        #1;
        chk("restart_dma_active", dma_active, 1);
        chk("restart_bus_enable", bus_enable, 0);
        chk("restart_reg_data", reg_data, 8'h20);
        mcyc();
        active_run(8'h20, 0, LEN);
        chk("restart_queue_empty", exp_q.size(), 0);
        chk("restart_done_dma_active", dma_active, 0);

        v = 8'($urandom);
        start_and_starting(v);
        active_run(eff_of(v), 0, 8'h30);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("async_dma_active", dma_active, 0);
        chk("async_oam_write", oam_write, 0);
        chk("async_bus_enable", bus_enable, 0);
        chk("async_cpu_low_data", cpu_low_data, 8'hFF);
        chk("async_reg_data", reg_data, 0);
        chk("async_oam_addr", oam_addr, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) mcyc();
        chk("post_reset_dma_active", dma_active, 0);

        m_en = 1'b0;
        cpu_addr     = 16'hFF46;
        cpu_enable   = 1'b1;
        cpu_write    = 1'b1;
        cpu_data_out = 8'h5A;
        repeat (3) mcyc();
        chk("mlow_reg_data", reg_data, 0);
        chk("mlow_dma_active", dma_active, 0);
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
        m_en       = 1'b1;
        repeat (3) mcyc();
        chk("mlow_after_dma_active", dma_active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
